// File: rtl/param_register_file.sv
// Parametrised MIPS-style register file: registered reads with write-first forwarding,
// hardware clear sweep after reset. Define REGFILE_ZERO_REG_EN for hard-wired $zero at address 0.
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_RD*ADDR_W-1:0]   Read_Register,
  input  logic [NUM_RD-1:0]          Read_Enable,
  output logic [NUM_RD*DATA_W-1:0]   Read_Data,
  input  logic [ADDR_W-1:0]          Write_Register,
  input  logic [DATA_W-1:0]          Write_Data,
  input  logic                       RegWrite,
  output logic                       Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                          state;
  state_t                          state_next;
  logic [ADDR_W-1:0]               clear_idx;
  logic [ADDR_W-1:0]               clear_idx_next;
  logic [DATA_W-1:0]               regs [DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0]   read_q;
  logic [NUM_RD-1:0][DATA_W-1:0]   read_fwd;
  logic                            write_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
    end
  end

  // The sweep leaves CLEAR on the same edge that zeroes the last entry.
  always_comb begin
    state_next     = state;
    clear_idx_next = clear_idx;
    Busy           = 1'b0;
    if (state == CLEAR) begin
      Busy           = 1'b1;
      clear_idx_next = clear_idx + 1'b1;
      if (clear_idx == {ADDR_W{1'b1}}) begin
        state_next = READY;
      end
    end
  end

`ifdef REGFILE_ZERO_REG_EN
  assign write_en = RegWrite && (state == READY) && (Write_Register != '0);
`else
  assign write_en = RegWrite && (state == READY);
`endif

  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      regs[clear_idx] <= '0;
    end else if (write_en) begin
      regs[Write_Register] <= Write_Data;
    end
  end

  // Write-first bypass: a same-edge write to the read address wins over the stored value.
  always_comb begin
    read_fwd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      read_fwd[k] = regs[Read_Register[k*ADDR_W +: ADDR_W]];
      if (write_en && (Write_Register == Read_Register[k*ADDR_W +: ADDR_W])) begin
        read_fwd[k] = Write_Data;
      end
`ifdef REGFILE_ZERO_REG_EN
      if (Read_Register[k*ADDR_W +: ADDR_W] == '0) begin
        read_fwd[k] = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      read_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (Read_Enable[k]) begin
          read_q[k] <= (state == CLEAR) ? '0 : read_fwd[k];
        end
      end
    end
  end

  assign Read_Data = read_q;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file (default 32x32, two read ports):
// table vectors plus random traffic through a scoreboard, and clear/reset sequences.
module tb_param_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic [NUM_RD*ADDR_W-1:0] Read_Register = '0;
  logic [NUM_RD-1:0]        Read_Enable = '0;
  logic [NUM_RD*DATA_W-1:0] Read_Data;
  logic [ADDR_W-1:0]        Write_Register = '0;
  logic [DATA_W-1:0]        Write_Data = '0;
  logic                     RegWrite = 1'b0;
  logic                     Busy;

  param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .CLK(CLK),
    .RST(RST),
    .Read_Register(Read_Register),
    .Read_Enable(Read_Enable),
    .Read_Data(Read_Data),
    .Write_Register(Write_Register),
    .Write_Data(Write_Data),
    .RegWrite(RegWrite),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]        re;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } exp_t;

  int                n_vectors = 0;
  int                n_miscompares = 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_rd [NUM_RD];
  exp_t              sb [$];
  vec_t              vecs [12];

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] ra, input logic we,
                                                  input logic [ADDR_W-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
`ifdef REGFILE_ZERO_REG_EN
    if (ra == '0) return '0;
`endif
    if (we && wa == ra) return wd;
    return mem[ra];
  endfunction

  // Drive one cycle of stimulus, queue the expected read data, then compare after the edge.
  task automatic applyStimulus(input vec_t v, input string name);
    exp_t e;
    @(negedge CLK);
    Read_Enable    = v.re;
    Read_Register  = {v.ra1, v.ra0};
    RegWrite       = v.we;
    Write_Register = v.wa;
    Write_Data     = v.wd;
    if (v.re[0]) exp_rd[0] = modelRead(v.ra0, v.we, v.wa, v.wd);
    if (v.re[1]) exp_rd[1] = modelRead(v.ra1, v.we, v.wa, v.wd);
`ifdef REGFILE_ZERO_REG_EN
    if (v.we && v.wa != '0) mem[v.wa] = v.wd;
`else
    if (v.we) mem[v.wa] = v.wd;
`endif
    e.d0 = exp_rd[0];
    e.d1 = exp_rd[1];
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    checkOutput({name, "_port0"}, Read_Data[DATA_W-1:0], e.d0);
    checkOutput({name, "_port1"}, Read_Data[2*DATA_W-1:DATA_W], e.d1);
    checkOutput({name, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  // Reset, optionally re-assert reset after abort_at sweep edges, then time the full clear.
  task automatic clearSequence(input int abort_at, input string name);
    int cycles;
    @(negedge CLK);
    RST            = 1'b1;
    RegWrite       = 1'b1;
    Write_Register = 5'd3;
    Write_Data     = 32'hDEAD_BEEF;
    Read_Enable    = 2'b11;
    Read_Register  = {5'd3, 5'd3};
    #1;
    checkOutput({name, "_rst_busy"}, {31'd0, Busy}, 32'd1);
    checkOutput({name, "_rst_data0"}, Read_Data[DATA_W-1:0], 32'd0);
    checkOutput({name, "_rst_data1"}, Read_Data[2*DATA_W-1:DATA_W], 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checkOutput({name, "_midrst_busy"}, {31'd0, Busy}, 32'd1);
      @(negedge CLK);
      RST = 1'b0;
    end
    cycles = 0;
    do begin
      @(posedge CLK);
      #1;
      cycles++;
    end while (Busy && cycles < 100);
    checkOutput({name, "_busy_cycles"}, cycles, 32'd32);
    checkOutput({name, "_clear_data0"}, Read_Data[DATA_W-1:0], 32'd0);
    checkOutput({name, "_clear_data1"}, Read_Data[2*DATA_W-1:DATA_W], 32'd0);
    @(negedge CLK);
    RegWrite    = 1'b0;
    Read_Enable = 2'b00;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{2'b11, 5'd3,  5'd3,  1'b0, 5'd0,  32'h0000_0000};
    vecs[1]  = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd7,  32'h1234_5678};
    vecs[2]  = '{2'b11, 5'd7,  5'd8,  1'b0, 5'd0,  32'h0000_0000};
    vecs[3]  = '{2'b11, 5'd9,  5'd9,  1'b1, 5'd9,  32'hCAFE_0001};
    vecs[4]  = '{2'b01, 5'd7,  5'd0,  1'b0, 5'd0,  32'h0000_0000};
    vecs[5]  = '{2'b00, 5'd7,  5'd7,  1'b1, 5'd7,  32'h0000_0000};
    vecs[6]  = '{2'b11, 5'd9,  5'd7,  1'b0, 5'd0,  32'h0000_0000};
    vecs[7]  = '{2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF};
    vecs[8]  = '{2'b11, 5'd0,  5'd9,  1'b0, 5'd0,  32'h0000_0000};
    vecs[9]  = '{2'b10, 5'd30, 5'd31, 1'b1, 5'd31, 32'hA5A5_A5A5};
    vecs[10] = '{2'b11, 5'd31, 5'd31, 1'b1, 5'd30, 32'h5A5A_0F0F};
    vecs[11] = '{2'b11, 5'd30, 5'd31, 1'b0, 5'd0,  32'h0000_0000};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (2) @(posedge CLK);

    $display("[TB] reset and clear sweep");
    clearSequence(0, "clear");

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      v.re  = 2'($urandom_range(0, 3));
      v.ra0 = 5'($urandom_range(0, 31));
      v.ra1 = (i % 4 == 0) ? v.ra0 : 5'($urandom_range(0, 31));
      v.we  = 1'($urandom_range(0, 1));
      v.wa  = (i % 3 == 0) ? v.ra1 : 5'($urandom_range(0, 31));
      v.wd  = $urandom;
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    $display("[TB] reset in the middle of the clear sweep");
    clearSequence(10, "midclear");
    for (int a = 0; a < DEPTH; a += 2) begin
      v = '{2'b11, 5'(a), 5'(a + 1), 1'b0, 5'd0, 32'h0};
      applyStimulus(v, $sformatf("sweep%0d", a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
